// File: rtl/flag_reg_unit_if.sv
// Bundles the flag unit's control inputs and its status outputs into one port.
// Latency: none. The interface holds wires only.
// Backpressure: stall travels in this bundle. There is no ready/valid return path.
// Ports: stall, alu_flags/alu_we, flag_op, br_taken/br_type, int_save,
//        rti_restore (master -> slave); flag_mask, stk_depth, stk_err (slave -> master).
interface flag_reg_unit_if;
  logic       stall;
  logic [3:0] alu_flags;   // [0]=Z [1]=N [2]=C [3]=V
  logic [3:0] alu_we;
  logic [1:0] flag_op;     // 01 SETC, 10 CLRC, else none
  logic       br_taken;
  logic [2:0] br_type;     // 1 JZ, 2 JN, 3 JC, 4 JV
  logic       int_save;
  logic       rti_restore;
  logic [3:0] flag_mask;
  logic [1:0] stk_depth;
  logic       stk_err;

  modport master (
    output stall, alu_flags, alu_we, flag_op, br_taken, br_type, int_save, rti_restore,
    input  flag_mask, stk_depth, stk_err
  );

  modport slave (
    input  stall, alu_flags, alu_we, flag_op, br_taken, br_type, int_save, rti_restore,
    output flag_mask, stk_depth, stk_err
  );
endinterface

// File: rtl/flag_reg_unit.sv
// Condition-code register (Z/N/C/V) with a 2-deep interrupt shadow stack and a sticky error flag.
// Latency: 1 cycle. Every update appears on flag_mask after the edge that causes it.
// Backpressure: stall=1 freezes all state. There is no output handshake.
// Ports: clk, rst_n (async, active low); fr (slave modport) carries the ALU, flag-op,
//        branch and interrupt controls in, and flag_mask, stk_depth, stk_err out.
module flag_reg_unit (
  input  logic            clk,
  input  logic            rst_n,
  flag_reg_unit_if.slave  fr
);

  logic [3:0] ccr_q,  ccr_d;
  logic [3:0] stk0_q, stk0_d;
  logic [3:0] stk1_q, stk1_d;
  logic [1:0] depth_q, depth_d;
  logic       err_q,  err_d;

  logic [3:0] upd_ccr;
  logic [3:0] clr_mask;
  logic [3:0] stk_top;

  // Normal CCR path. Apply ALU writes, then SETC/CLRC, then the branch-consume clear.
  // The clear is applied last, so it wins over any write to the same bit.
  always_comb begin
    clr_mask = 4'b0000;
    if (fr.br_taken) begin
      case (fr.br_type)
        3'd1:    clr_mask = 4'b0001;
        3'd2:    clr_mask = 4'b0010;
        3'd3:    clr_mask = 4'b0100;
        3'd4:    clr_mask = 4'b1000;
        default: clr_mask = 4'b0000;
      endcase
    end

    upd_ccr = (ccr_q & ~fr.alu_we) | (fr.alu_flags & fr.alu_we);
    case (fr.flag_op)
      2'b01:   upd_ccr[2] = 1'b1;
      2'b10:   upd_ccr[2] = 1'b0;
      default: ;
    endcase
    upd_ccr = upd_ccr & ~clr_mask;
  end

  // The top of the LIFO is the entry just below depth.
  assign stk_top = (depth_q == 2'd2) ? stk1_q : stk0_q;

  always_comb begin
    ccr_d   = ccr_q;
    stk0_d  = stk0_q;
    stk1_d  = stk1_q;
    depth_d = depth_q;
    err_d   = err_q;

    if (!fr.stall) begin
      if (fr.rti_restore && (depth_q != 2'd0)) begin
        // A restore takes the whole cycle. A save in the same cycle is dropped and counts as an error.
        ccr_d   = stk_top;
        depth_d = depth_q - 2'd1;
        if (fr.int_save) err_d = 1'b1;
      end else begin
        ccr_d = upd_ccr;
        if (fr.rti_restore) begin
          // Underflow. A save in the same cycle is also dropped, because restore has priority.
          err_d = 1'b1;
        end else if (fr.int_save) begin
          // The pushed value is the CCR before this cycle's update.
          case (depth_q)
            2'd0: begin
              stk0_d  = ccr_q;
              depth_d = 2'd1;
            end
            2'd1: begin
              stk1_d  = ccr_q;
              depth_d = 2'd2;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q   <= 4'b0000;
      stk0_q  <= 4'b0000;
      stk1_q  <= 4'b0000;
      depth_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      ccr_q   <= ccr_d;
      stk0_q  <= stk0_d;
      stk1_q  <= stk1_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign fr.flag_mask = ccr_q;
  assign fr.stk_depth = depth_q;
  assign fr.stk_err   = err_q;

endmodule

// File: tb/tb_flag_reg_unit.sv
module tb_flag_reg_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flag_reg_unit_if bus ();

  flag_reg_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fr    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: CCR value, a queue used as the LIFO, and the sticky error bit.
  logic [3:0] m_ccr = 4'b0000;
  logic [3:0] m_stk[$];
  bit         m_err = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ccr = 4'b0000;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit st, input logic [3:0] we, input logic [3:0] fl,
                            input logic [1:0] op, input bit bt, input logic [2:0] bty,
                            input bit sv, input bit rt);
    logic [3:0] nxt;
    int idx;
    if (!st) begin
      if (rt && m_stk.size() > 0) begin
        m_ccr = m_stk.pop_back();
        if (sv) m_err = 1'b1;
      end else begin
        if (rt) m_err = 1'b1;
        nxt = m_ccr;
        for (int i = 0; i < 4; i++) if (we[i]) nxt[i] = fl[i];
        if (op == 2'b01) nxt[2] = 1'b1;
        else if (op == 2'b10) nxt[2] = 1'b0;
        idx = int'(bty) - 1;
        if (bt && idx >= 0 && idx <= 3) nxt[idx] = 1'b0;
        if (sv && !rt) begin
          if (m_stk.size() < 2) m_stk.push_back(m_ccr);
          else m_err = 1'b1;
        end
        m_ccr = nxt;
      end
    end
  endtask

  task automatic check_model();
    chk("model_mask",  bus.flag_mask, m_ccr);
    chk("model_depth", {2'b00, bus.stk_depth}, 4'(m_stk.size()));
    chk("model_err",   {3'b000, bus.stk_err}, {3'b000, m_err});
  endtask

  task automatic drive(input bit st, input logic [3:0] we, input logic [3:0] fl,
                       input logic [1:0] op, input bit bt, input logic [2:0] bty,
                       input bit sv, input bit rt);
    bus.stall       = st;
    bus.alu_we      = we;
    bus.alu_flags   = fl;
    bus.flag_op     = op;
    bus.br_taken    = bt;
    bus.br_type     = bty;
    bus.int_save    = sv;
    bus.rti_restore = rt;
    @(posedge clk);
    #1;
    model_step(st, we, fl, op, bt, bty, sv, rt);
    check_model();
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic set_ccr(input logic [3:0] v);
    drive(1'b0, 4'hF, v, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.stall = 1'b0; bus.alu_we = 4'h0; bus.alu_flags = 4'h0; bus.flag_op = 2'b00;
    bus.br_taken = 1'b0; bus.br_type = 3'd0; bus.int_save = 1'b0; bus.rti_restore = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_mask",  bus.flag_mask, 4'b0000);
    chk("rst_depth", {2'b00, bus.stk_depth}, 4'b0000);
    chk("rst_err",   {3'b000, bus.stk_err}, 4'b0000);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.stall = 1'b0; bus.alu_we = 4'h0; bus.alu_flags = 4'h0; bus.flag_op = 2'b00;
    bus.br_taken = 1'b0; bus.br_type = 3'd0; bus.int_save = 1'b0; bus.rti_restore = 1'b0;
    do_reset();

    // ALU write, then a stall that must hold the value.
    set_ccr(4'b0101);
    chk("alu_write", bus.flag_mask, 4'b0101);
    drive(1'b1, 4'hF, 4'b1010, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("stall_hold", bus.flag_mask, 4'b0101);

    // A taken JZ consumes Z. A non-consuming branch type clears nothing.
    set_ccr(4'b0001);
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0);
    chk("jz_consume", bus.flag_mask, 4'b0000);
    set_ccr(4'b0001);
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 3'd6, 1'b0, 1'b0);
    chk("br_other", bus.flag_mask, 4'b0001);

    // SETC together with a taken JC: the consume clear wins.
    set_ccr(4'b0000);
    drive(1'b0, 4'h0, 4'h0, 2'b01, 1'b1, 3'd3, 1'b0, 1'b0);
    chk("setc_vs_jc", bus.flag_mask, 4'b0000);

    // Save, overwrite with the ALU, then restore.
    set_ccr(4'b1001);
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("save_depth", {2'b00, bus.stk_depth}, 4'd1);
    set_ccr(4'b0110);
    chk("alu_after_save", bus.flag_mask, 4'b0110);
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("rti_mask",  bus.flag_mask, 4'b1001);
    chk("rti_depth", {2'b00, bus.stk_depth}, 4'd0);
    chk("rti_err",   {3'b000, bus.stk_err}, 4'd0);

    // Three saves overflow. Restores come back in LIFO order, and the third restore underflows.
    drive(1'b0, 4'hF, 4'b0011, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 4'hF, 4'b0111, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 4'h0,    2'b00, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("ovf_depth", {2'b00, bus.stk_depth}, 4'd2);
    chk("ovf_err",   {3'b000, bus.stk_err}, 4'd1);
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("pop2", bus.flag_mask, 4'b0011);
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("pop1", bus.flag_mask, 4'b1001);
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("unf_depth", {2'b00, bus.stk_depth}, 4'd0);
    chk("unf_mask",  bus.flag_mask, 4'b1001);

    // Save and restore in the same cycle with depth 1, then an asynchronous reset mid-cycle.
    do_reset();
    set_ccr(4'b0100);
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0);
    set_ccr(4'b1000);
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1);
    chk("coll_depth", {2'b00, bus.stk_depth}, 4'd0);
    chk("coll_mask",  bus.flag_mask, 4'b0100);
    chk("coll_err",   {3'b000, bus.stk_err}, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mask",  bus.flag_mask, 4'b0000);
    chk("async_depth", {2'b00, bus.stk_depth}, 4'd0);
    chk("async_err",   {3'b000, bus.stk_err}, 4'd0);
    model_reset();
    do_reset();
    idle();

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 6) == 0,
              4'($urandom), 4'($urandom), 2'($urandom),
              1'($urandom), 3'($urandom),
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
